ex_flags_stage: RTL and testbench

Execute-to-writeback pipeline stage that sits directly downstream of the 32-bit add/subtract unit. It registers the arithmetic result with a valid/ready handshake toward writeback and holds the architectural NZCV status register. It also evaluates a 4-bit branch condition against the flags, so branch resolution and result writeback leave the execute stage on the same beat.

---
 rtl/ex_pkg.sv | 33 +++
 rtl/ex_flags_stage_if.sv | 40 ++++
 rtl/cond_eval.sv | 39 +++
 rtl/ex_flags_stage.sv | 135 +++++++++++++
 tb/tb_ex_flags_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: condition-code encoding and NZCV bit positions.
package ex_pkg;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_LO = 4'b0010,
        COND_HS = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/ex_flags_stage_if.sv
// Handshake and payload bundle between the adder, the flags stage and writeback.
interface ex_flags_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic              in_c;
    logic              in_v;
    logic              in_n;
    logic              in_z;
    logic              in_set_flags;
    logic              in_is_branch;
    logic [3:0]        in_cond;
    logic [RD_W-1:0]   in_rd;
    logic              in_wb_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wb_en;
    logic              out_is_branch;
    logic              out_br_taken;
    logic [3:0]        nzcv;

    modport slave (
        input  in_valid, in_sum, in_c, in_v, in_n, in_z, in_set_flags,
               in_is_branch, in_cond, in_rd, in_wb_en, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wb_en,
               out_is_branch, out_br_taken, nzcv
    );

    modport master (
        output in_valid, in_sum, in_c, in_v, in_n, in_z, in_set_flags,
               in_is_branch, in_cond, in_rd, in_wb_en, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wb_en,
               out_is_branch, out_br_taken, nzcv
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over an NZCV flag vector.
module cond_eval
    import ex_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n_s, z_s, c_s, v_s;

    assign n_s = nzcv[NZCV_N];
    assign z_s = nzcv[NZCV_Z];
    assign c_s = nzcv[NZCV_C];
    assign v_s = nzcv[NZCV_V];

    // C is the borrow flag: LO means a < b unsigned.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z_s;
            COND_NE: taken = ~z_s;
            COND_LO: taken = c_s;
            COND_HS: taken = ~c_s;
            COND_MI: taken = n_s;
            COND_PL: taken = ~n_s;
            COND_VS: taken = v_s;
            COND_VC: taken = ~v_s;
            COND_HI: taken = ~c_s & ~z_s;
            COND_LS: taken = c_s | z_s;
            COND_GE: taken = (n_s == v_s);
            COND_LT: taken = (n_s != v_s);
            COND_GT: taken = ~z_s & (n_s == v_s);
            COND_LE: taken = z_s | (n_s != v_s);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_flags_stage.sv
// Execute-to-writeback register stage with NZCV status and branch resolution.
// Define SKID_BUFFER_EN for a registered in_ready backed by a one-entry skid buffer.
module ex_flags_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    ex_flags_stage_if.slave  bus
);
    localparam int PAY_W = DATA_W + RD_W + 3;

    logic [3:0]       nzcv_r;
    logic             out_valid_r;
    logic [PAY_W-1:0] out_pay_r;
    logic [PAY_W-1:0] in_pay_s;
    logic             accept_s;
    logic             xfer_s;
    logic             cond_true_s;
    logic             taken_s;
    logic             in_ready_s;

    // Evaluated against the flags before this beat's own update.
    cond_eval u_cond_eval (
        .cond  (cond_e'(bus.in_cond)),
        .nzcv  (nzcv_r),
        .taken (cond_true_s)
    );

    assign taken_s  = bus.in_is_branch & cond_true_s;
    assign in_pay_s = {bus.in_sum, bus.in_rd, bus.in_wb_en, bus.in_is_branch, taken_s};
    assign accept_s = bus.in_valid & in_ready_s;
    assign xfer_s   = out_valid_r & bus.out_ready;

    // Status register: loads only on an accepted flag-setting beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv_r <= 4'b0000;
        end else if (accept_s && bus.in_set_flags) begin
            nzcv_r <= pack_nzcv(bus.in_n, bus.in_z, bus.in_c, bus.in_v);
        end
    end

`ifdef SKID_BUFFER_EN
    logic             skid_valid_r;
    logic [PAY_W-1:0] skid_pay_r;
    logic             in_ready_r;
    logic             out_load_s;
    logic             skid_to_out_s;
    logic             skid_load_s;
    logic             out_valid_nxt_s;
    logic             skid_valid_nxt_s;

    assign in_ready_s = in_ready_r;

    // Steering: an accept only happens with the skid entry empty.
    always_comb begin
        out_load_s       = 1'b0;
        skid_to_out_s    = 1'b0;
        skid_load_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (skid_valid_r) begin
            if (xfer_s) begin
                skid_to_out_s    = 1'b1;
                skid_valid_nxt_s = 1'b0;
                out_valid_nxt_s  = 1'b1;
            end else begin
                out_valid_nxt_s  = out_valid_r;
            end
        end else if (!out_valid_r || xfer_s) begin
            if (accept_s) begin
                out_load_s      = 1'b1;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Output register, skid entry and registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_pay_r    <= {PAY_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_pay_r   <= {PAY_W{1'b0}};
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
            if (out_load_s) begin
                out_pay_r <= in_pay_s;
            end else if (skid_to_out_s) begin
                out_pay_r <= skid_pay_r;
            end
            if (skid_load_s) begin
                skid_pay_r <= in_pay_s;
            end
        end
    end
`else
    assign in_ready_s = ~out_valid_r | bus.out_ready;

    // Single output register; a same-edge accept and transfer keeps it valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pay_r   <= {PAY_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_pay_r   <= in_pay_s;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign {bus.out_result, bus.out_rd, bus.out_wb_en,
            bus.out_is_branch, bus.out_br_taken} = out_pay_r;
    assign bus.nzcv      = nzcv_r;

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed self-checking bench for ex_flags_stage (works with or without SKID_BUFFER_EN).
module tb_ex_flags_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ex_flags_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

    ex_flags_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_sum = 32'd0; bus.in_c = 1'b0; bus.in_v = 1'b0;
        bus.in_n = 1'b0; bus.in_z = 1'b0; bus.in_set_flags = 1'b0; bus.in_is_branch = 1'b0;
        bus.in_cond = 4'b0000; bus.in_rd = 5'd0; bus.in_wb_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for one edge; callers guarantee in_ready is high.
    task automatic send(input logic [31:0] sum, input logic [3:0] f, input logic set,
                        input logic br, input logic [3:0] cond);
        bus.in_valid = 1'b1; bus.in_sum = sum; bus.in_rd = sum[4:0]; bus.in_wb_en = 1'b1;
        bus.in_n = f[3]; bus.in_z = f[2]; bus.in_c = f[1]; bus.in_v = f[0];
        bus.in_set_flags = set; bus.in_is_branch = br; bus.in_cond = cond;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step(); step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (bus.nzcv !== 4'b0000) begin miscompares++; $display("FAIL reset_nzcv got=%b exp=0000", bus.nzcv); end
        vectors++; if (bus.out_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", bus.out_result); end
        vectors++; if (bus.out_br_taken !== 1'b0) begin miscompares++; $display("FAIL reset_taken got=%b exp=0", bus.out_br_taken); end
        rst = 1'b0;
        step();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_flag_update();
        bus.out_ready = 1'b1;
        send(32'h0000_0010, 4'b0100, 1'b1, 1'b0, COND_EQ);
        vectors++; if (bus.nzcv !== 4'b0100) begin miscompares++; $display("FAIL flag_load got=%b exp=0100", bus.nzcv); end
        vectors++; if (bus.out_result !== 32'h10) begin miscompares++; $display("FAIL flag_result got=%h exp=10", bus.out_result); end
        send(32'h0000_0011, 4'b1011, 1'b0, 1'b1, COND_EQ);
        vectors++; if (bus.out_br_taken !== 1'b1) begin miscompares++; $display("FAIL beq_taken got=%b exp=1", bus.out_br_taken); end
        vectors++; if (bus.nzcv !== 4'b0100) begin miscompares++; $display("FAIL flag_hold got=%b exp=0100", bus.nzcv); end
        send(32'h0000_0012, 4'b0000, 1'b0, 1'b1, COND_NE);
        vectors++; if (bus.out_br_taken !== 1'b0) begin miscompares++; $display("FAIL bne_taken got=%b exp=0", bus.out_br_taken); end
        vectors++; if (bus.out_rd !== 5'h12) begin miscompares++; $display("FAIL bne_rd got=%h exp=12", bus.out_rd); end
        // Flag inputs without a valid beat must not touch the register.
        bus.in_set_flags = 1'b1; bus.in_n = 1'b1; bus.in_c = 1'b1;
        step();
        idle_inputs();
        vectors++; if (bus.nzcv !== 4'b0100) begin miscompares++; $display("FAIL flag_no_accept got=%b exp=0100", bus.nzcv); end
    endtask

    task automatic test_same_beat();
        bus.out_ready = 1'b1;
        send(32'd1, 4'b0000, 1'b1, 1'b0, COND_AL);
        vectors++; if (bus.nzcv !== 4'b0000) begin miscompares++; $display("FAIL same_pre got=%b exp=0000", bus.nzcv); end
        send(32'd5, 4'b0100, 1'b1, 1'b1, COND_EQ);
        vectors++; if (bus.out_br_taken !== 1'b0) begin miscompares++; $display("FAIL same_taken got=%b exp=0", bus.out_br_taken); end
        vectors++; if (bus.out_is_branch !== 1'b1) begin miscompares++; $display("FAIL same_isbr got=%b exp=1", bus.out_is_branch); end
        vectors++; if (bus.nzcv !== 4'b0100) begin miscompares++; $display("FAIL same_nzcv got=%b exp=0100", bus.nzcv); end
    endtask

    task automatic test_conditions();
        cond_e c1[6] = '{COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV};
        logic  e1[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        cond_e c2[3] = '{COND_LO, COND_HI, COND_LS};
        logic  e2[3] = '{1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        send(32'd0, 4'b1001, 1'b1, 1'b0, COND_AL);
        for (int i = 0; i < 6; i++) begin
            send(32'(i), 4'b0000, 1'b0, 1'b1, c1[i]);
            vectors++; if (bus.out_br_taken !== e1[i]) begin miscompares++; $display("FAIL cond_1001_%0d got=%b exp=%b", i, bus.out_br_taken, e1[i]); end
        end
        send(32'd0, 4'b0010, 1'b1, 1'b0, COND_AL);
        for (int i = 0; i < 3; i++) begin
            send(32'(i), 4'b0000, 1'b0, 1'b1, c2[i]);
            vectors++; if (bus.out_br_taken !== e2[i]) begin miscompares++; $display("FAIL cond_0010_%0d got=%b exp=%b", i, bus.out_br_taken, e2[i]); end
        end
        send(32'd9, 4'b0000, 1'b0, 1'b0, COND_AL);
        vectors++; if (bus.out_br_taken !== 1'b0) begin miscompares++; $display("FAIL notbr_taken got=%b exp=0", bus.out_br_taken); end
    endtask

    task automatic test_backpressure();
        logic ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   sent = 0;
        int   got  = 0;
        bus.out_ready = 1'b1;
        step();
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            bus.out_ready = ready_pat[cyc % 4];
            bus.in_valid  = (sent < 8);
            bus.in_sum    = 32'(sent);
            bus.in_rd     = 5'(sent);
            #3;
            if (bus.out_valid && bus.out_ready) begin
                vectors++; if (bus.out_result !== 32'(got)) begin miscompares++; $display("FAIL bp_order got=%0d exp=%0d", bus.out_result, got); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        idle_inputs();
        vectors++; if (got !== 8) begin miscompares++; $display("FAIL bp_count got=%0d exp=8", got); end
    endtask

    task automatic test_stall_fill();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_sum = 32'd50;
        step();
`ifdef SKID_BUFFER_EN
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_one got=%b exp=1", bus.in_ready); end
        bus.in_sum = 32'd51;
        step();
        idle_inputs();
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_two got=%b exp=0", bus.in_ready); end
        vectors++; if (bus.out_result !== 32'd50) begin miscompares++; $display("FAIL skid_head got=%0d exp=50", bus.out_result); end
        bus.out_ready = 1'b1;
        step();
        vectors++; if (bus.out_result !== 32'd51) begin miscompares++; $display("FAIL skid_move got=%0d exp=51", bus.out_result); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_free got=%b exp=1", bus.in_ready); end
`else
        idle_inputs();
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready got=%b exp=0", bus.in_ready); end
        vectors++; if (bus.out_result !== 32'd50) begin miscompares++; $display("FAIL stall_head got=%0d exp=50", bus.out_result); end
        bus.out_ready = 1'b1;
`endif
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_throughput();
        int got = 0;
        bus.out_ready = 1'b1;
        step();
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.in_valid = (cyc < 16);
            bus.in_sum   = 32'(200 + cyc);
            #3;
            if (cyc >= 1 && cyc <= 16) begin
                vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL tp_valid cyc=%0d got=%b exp=1", cyc, bus.out_valid); end
            end
            if (bus.in_valid) begin
                vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL tp_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                vectors++; if (bus.out_result !== 32'(200 + got)) begin miscompares++; $display("FAIL tp_data got=%0d exp=%0d", bus.out_result, 200 + got); end
                got++;
            end
            step();
        end
        idle_inputs();
        vectors++; if (got !== 16) begin miscompares++; $display("FAIL tp_count got=%0d exp=16", got); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send(32'd77, 4'b1111, 1'b1, 1'b0, COND_AL);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got=%b exp=1", bus.out_valid); end
        vectors++; if (bus.nzcv !== 4'b1111) begin miscompares++; $display("FAIL mid_pre_nzcv got=%b exp=1111", bus.nzcv); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (bus.nzcv !== 4'b0000) begin miscompares++; $display("FAIL mid_async_nzcv got=%b exp=0000", bus.nzcv); end
        vectors++; if (bus.out_result !== 32'd0) begin miscompares++; $display("FAIL mid_async_result got=%h exp=0", bus.out_result); end
        step();
        rst = 1'b0;
        step();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_post_valid got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flag_update();
        test_same_beat();
        test_conditions();
        test_backpressure();
        test_stall_fill();
        test_throughput();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
